crossing_gate_actuator: RTL and testbench

//  Field-side responder to the crossing controller: consumes GATE/LIGHT commands, drives gate motor
//  up/down against limit switches, runs alternating warning lamps and bell, reports status/fault.

---
 rtl/crossing_pkg.sv | 20 ++
 rtl/sync_debounce.sv | 45 ++++
 rtl/crossing_gate_actuator.sv | 148 ++++++++++++++
 tb/tb_crossing_gate_actuator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
// Shared state encoding and output constants for the crossing gate actuator.
package crossing_pkg;

  typedef enum logic [2:0] {
    UP_IDLE  = 3'd0,
    WARN     = 3'd1,
    LOWERING = 3'd2,
    DOWN     = 3'd3,
    RAISING  = 3'd4,
    FAULT    = 3'd5
  } gate_state_t;

  localparam logic [1:0] LAMPS_OFF = 2'b00;
  localparam logic [1:0] MOTOR_OFF = 2'b00;

  function automatic logic is_flashing(gate_state_t s);
    return s != UP_IDLE;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser; with DEBOUNCE>0 the output asserts only after DEBOUNCE
// consecutive synced-high cycles and drops on the first synced-low cycle.
module sync_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic s1, s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_sync_only
      assign dout = s2;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE + 1);
      localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          cnt <= '0;
        else if (!s2)
          cnt <= '0;
        else if (cnt != CNT_FULL)
          cnt <= cnt + 1'b1;
      end

      assign dout = (cnt == CNT_FULL);
    end
  endgenerate

endmodule

// File: rtl/crossing_gate_actuator.sv
// Field-side gate/lamp/bell actuator; state and outputs change 2 edges after GATE.
// EXT_FLASH_EN: lamps follow the LIGHT input instead of the internal FLASH_DIV flasher.
module crossing_gate_actuator #(
  parameter int PRE_WARN   = 20,
  parameter int TRAVEL_MAX = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FLASH_DIV  = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic GATE,
  input  logic LIGHT,
  input  logic LIM_DN,
  input  logic LIM_UP,
  output logic MOT_DN,
  output logic MOT_UP,
  output logic LAMP_L,
  output logic LAMP_R,
  output logic BELL,
  output logic GATE_DOWN,
  output logic FAULT
);

  import crossing_pkg::*;

  localparam int TMAX = (PRE_WARN > TRAVEL_MAX) ? PRE_WARN : TRAVEL_MAX;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] WARN_LAST   = TW'(PRE_WARN - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_MAX - 1);

  gate_state_t state, next_state;
  logic [TW-1:0] tmr;
  logic g, dn, up;
  logic flash_next, flash_now;

  sync_debounce #(.DEBOUNCE(0)) u_gate (
    .clk(clk), .reset_n(reset_n), .din(GATE), .dout(g));
  sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_lim_dn (
    .clk(clk), .reset_n(reset_n), .din(LIM_DN), .dout(dn));
  sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_lim_up (
    .clk(clk), .reset_n(reset_n), .din(LIM_UP), .dout(up));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= UP_IDLE;
    else
      state <= next_state;
  end

  // Timer restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tmr <= '0;
    else if (next_state != state)
      tmr <= '0;
    else if (!(&tmr))
      tmr <= tmr + 1'b1;
  end

  always_comb begin
    next_state = state;
    if (dn && up) begin
      next_state = crossing_pkg::FAULT;
    end else begin
      case (state)
        UP_IDLE:  if (g) next_state = WARN;
        WARN: begin
          if (!g)                    next_state = UP_IDLE;
          else if (tmr == WARN_LAST) next_state = LOWERING;
        end
        LOWERING: begin
          if (tmr == TRAVEL_LAST) next_state = crossing_pkg::FAULT;
          else if (!g)            next_state = RAISING;
          else if (dn)            next_state = DOWN;
        end
        DOWN: begin
          if (!g)       next_state = RAISING;
          else if (!dn) next_state = LOWERING;
        end
        RAISING: begin
          if (tmr == TRAVEL_LAST) next_state = crossing_pkg::FAULT;
          else if (g)             next_state = LOWERING;
          else if (up)            next_state = UP_IDLE;
        end
        crossing_pkg::FAULT: next_state = crossing_pkg::FAULT;
        default:             next_state = crossing_pkg::FAULT;
      endcase
    end
  end

  assign flash_next = is_flashing(next_state);
  assign flash_now  = is_flashing(state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {MOT_DN, MOT_UP} <= MOTOR_OFF;
      BELL      <= 1'b0;
      GATE_DOWN <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      MOT_DN    <= (next_state == LOWERING);
      MOT_UP    <= (next_state == RAISING);
      BELL      <= flash_next && (next_state != RAISING);
      GATE_DOWN <= (next_state == DOWN);
      FAULT     <= (next_state == crossing_pkg::FAULT);
    end
  end

`ifdef EXT_FLASH_EN
  logic unused_flash;
  assign unused_flash = flash_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      {LAMP_L, LAMP_R} <= LAMPS_OFF;
    else if (!flash_next)
      {LAMP_L, LAMP_R} <= LAMPS_OFF;
    else
      {LAMP_L, LAMP_R} <= {LIGHT, ~LIGHT};
  end
`else
  localparam int DW = $clog2(FLASH_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(FLASH_DIV - 1);
  logic [DW-1:0] div;
  logic unused_light;
  assign unused_light = LIGHT;

  // Phase always starts left-lamp-on when flashing begins from UP_IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      {LAMP_L, LAMP_R} <= LAMPS_OFF;
    end else if (!flash_next) begin
      div <= '0;
      {LAMP_L, LAMP_R} <= LAMPS_OFF;
    end else if (!flash_now) begin
      div <= '0;
      {LAMP_L, LAMP_R} <= 2'b10;
    end else if (div == DIV_LAST) begin
      div <= '0;
      {LAMP_L, LAMP_R} <= {LAMP_R, LAMP_L};
    end else begin
      div <= div + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_crossing_gate_actuator.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_crossing_gate_actuator;

  localparam int PW = 4;
  localparam int TM = 16;
  localparam int DB = 2;
  localparam int FD = 3;

  localparam int S_IDLE = 0, S_WARN = 1, S_LOWER = 2, S_DOWN = 3, S_RAISE = 4, S_FAULT = 5;

  logic clk = 1'b0;
  logic reset_n, GATE, LIGHT, LIM_DN, LIM_UP;
  logic MOT_DN, MOT_UP, LAMP_L, LAMP_R, BELL, GATE_DOWN, FAULT;

  int tests = 0;
  int fails = 0;

  crossing_gate_actuator #(.PRE_WARN(PW), .TRAVEL_MAX(TM), .DEBOUNCE(DB), .FLASH_DIV(FD)) dut (
    .clk(clk), .reset_n(reset_n), .GATE(GATE), .LIGHT(LIGHT), .LIM_DN(LIM_DN), .LIM_UP(LIM_UP),
    .MOT_DN(MOT_DN), .MOT_UP(MOT_UP), .LAMP_L(LAMP_L), .LAMP_R(LAMP_R), .BELL(BELL),
    .GATE_DOWN(GATE_DOWN), .FAULT(FAULT));

  always #5 clk = ~clk;

  // Behavioural model: raw-input history per edge, state, time in state, time flashing.
  bit gh[8], dh[8], uh[8];
  int ms, age, fl;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms = S_IDLE; age = 0; fl = 0;
      for (int i = 0; i < 8; i++) begin gh[i] = 0; dh[i] = 0; uh[i] = 0; end
    end else begin
      bit g, dn, up;
      int nxt;
      g = gh[1];
      dn = 1; up = 1;
      for (int i = 2; i <= DB + 1; i++) begin dn &= dh[i]; up &= uh[i]; end
      nxt = ms;
      if (dn && up) nxt = S_FAULT;
      else case (ms)
        S_IDLE:  if (g) nxt = S_WARN;
        S_WARN:  if (!g) nxt = S_IDLE; else if (age == PW - 1) nxt = S_LOWER;
        S_LOWER: if (age == TM - 1) nxt = S_FAULT; else if (!g) nxt = S_RAISE; else if (dn) nxt = S_DOWN;
        S_DOWN:  if (!g) nxt = S_RAISE; else if (!dn) nxt = S_LOWER;
        S_RAISE: if (age == TM - 1) nxt = S_FAULT; else if (g) nxt = S_LOWER; else if (up) nxt = S_IDLE;
        default: nxt = S_FAULT;
      endcase
      if (nxt != ms) age = 0; else if (age < 1000) age++;
      if (nxt == S_IDLE || ms == S_IDLE) fl = 0; else fl++;
      ms = nxt;
      for (int i = 7; i > 0; i--) begin gh[i] = gh[i-1]; dh[i] = dh[i-1]; uh[i] = uh[i-1]; end
      gh[0] = GATE; dh[0] = LIM_DN; uh[0] = LIM_UP;
    end
  end

  always @(negedge clk) begin : compare
    logic [6:0] e, a;
    logic fon, lon;
    fon = (ms != S_IDLE);
    lon = fon && (((fl / FD) % 2) == 0);
    e = {ms == S_LOWER, ms == S_RAISE, lon, fon && !lon,
         fon && ms != S_RAISE, ms == S_DOWN, ms == S_FAULT};
    a = {MOT_DN, MOT_UP, LAMP_L, LAMP_R, BELL, GATE_DOWN, FAULT};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL model_cmp t=%0t dut={dn,up,l,r,bell,gd,flt}=%b expected=%b", $time, a, e);
    end
    tests++;
    if (MOT_DN && MOT_UP) begin
      fails++;
      $display("FAIL motor_excl t=%0t MOT_DN=1 MOT_UP=1 expected never both", $time);
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, |{MOT_DN, MOT_UP, LAMP_L, LAMP_R, BELL, GATE_DOWN, FAULT}, 1'b0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; GATE = 0; LIGHT = 0; LIM_DN = 0; LIM_UP = 0;
    cyc(3);
    chk_all_zero("reset_outputs");
    reset_n = 1'b1;
    cyc(3);

    // Normal close: GATE sampled at edge 0
    GATE = 1;
    cyc(3); chk("warn_bell", BELL, 1); chk("warn_lamp_l", LAMP_L, 1); chk("warn_no_motor", MOT_DN, 0);
    cyc(2); chk("flash_l_hold", LAMP_L, 1); chk("flash_r_hold", LAMP_R, 0);
    cyc(1); chk("flash_l_toggle", LAMP_L, 0); chk("flash_r_toggle", LAMP_R, 1); chk("prewarn_no_mot", MOT_DN, 0);
    cyc(1); chk("lower_mot_dn", MOT_DN, 1);
    LIM_DN = 1;
    cyc(4); chk("debounce_wait", GATE_DOWN, 0); chk("debounce_mot", MOT_DN, 1);
    cyc(1); chk("down_gate_down", GATE_DOWN, 1); chk("down_mot_off", MOT_DN, 0); chk("down_bell", BELL, 1);

    // Normal open
    GATE = 0;
    cyc(3); chk("raise_mot_up", MOT_UP, 1); chk("raise_bell_off", BELL, 0); chk("raise_gd_off", GATE_DOWN, 0);
    LIM_DN = 0; LIM_UP = 1;
    cyc(4); chk("raise_wait", MOT_UP, 1);
    cyc(1); chk_all_zero("open_idle");

    // Timeout: no down-limit ever
    GATE = 1; LIM_UP = 0;
    cyc(7); chk("to_mot_dn", MOT_DN, 1);
    cyc(15); chk("to_before", FAULT, 0); chk("to_before_mot", MOT_DN, 1);
    cyc(1); chk("to_fault", FAULT, 1); chk("to_mot_dn_off", MOT_DN, 0); chk("to_mot_up_off", MOT_UP, 0);
    chk("to_bell", BELL, 1);
    GATE = 0;
    cyc(10); chk("fault_sticky", FAULT, 1); chk("fault_lamps_opp", LAMP_L ^ LAMP_R, 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset_from_fault");
    cyc(2); reset_n = 1'b1;

    // Reset mid-LOWERING
    cyc(2); GATE = 1;
    cyc(9); chk("mid_lower_mot", MOT_DN, 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset_async_lower");
    GATE = 0;
    cyc(2); reset_n = 1'b1;
    cyc(3); chk_all_zero("idle_after_reset");

    // Reversal, re-close without re-warn, then both limits in DOWN
    GATE = 1;
    cyc(9); chk("rev_lowering", MOT_DN, 1);
    GATE = 0;
    cyc(2); chk("rev_still_lower", MOT_DN, 1);
    cyc(1); chk("rev_raise", MOT_UP, 1); chk("rev_dn_off", MOT_DN, 0);
    GATE = 1;
    cyc(3); chk("reclose_no_warn", MOT_DN, 1);
    LIM_DN = 1;
    cyc(5); chk("both_down_first", GATE_DOWN, 1);
    LIM_UP = 1;
    cyc(4); chk("both_pre", FAULT, 0);
    cyc(1); chk("both_fault", FAULT, 1); chk("both_gd_off", GATE_DOWN, 0);
    #2 reset_n = 1'b0;
    GATE = 0; LIM_DN = 0; LIM_UP = 0;
    cyc(2); reset_n = 1'b1;

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) GATE = ~GATE;
      if ($urandom_range(0, 14) == 0) LIM_DN = ~LIM_DN;
      if ($urandom_range(0, 14) == 0) LIM_UP = ~LIM_UP;
      LIGHT = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 249) == 0) begin
        #2 reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
      end
    end

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
